// File: rtl/neuron_mac.sv
// Single-neuron MAC: streams numInputs activations against stored weights, adds the aligned bias, emits a 2*dataWidth sum.
// Latency: last input accepted at edge T -> sum_valid pulses in cycle T+5 (3 pipe stages + BIAS + OUT).
// Backpressure: in_ready is low from last-input acceptance until the result is out; in_valid is ignored meanwhile.
// Optional: define NEURON_SAT_EN for saturating accumulation and bias add (default build wraps).
module neuron_mac #(
    parameter int dataWidth = 16,
    parameter int intPart   = 4,
    parameter int numInputs = 784,
    parameter int addrWidth = $clog2(numInputs)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wt_wr,
    input  logic [addrWidth-1:0]   wt_addr,
    input  logic [dataWidth-1:0]   wt_data,
    input  logic                   bias_wr,
    input  logic [dataWidth-1:0]   bias_data,
    input  logic                   in_valid,
    input  logic [dataWidth-1:0]   in_data,
    output logic                   in_ready,
    output logic                   sum_valid,
    output logic [2*dataWidth-1:0] sum_out
);

    localparam int SW   = 2 * dataWidth;
    localparam int FRAC = dataWidth - intPart;
    localparam int CW   = $clog2(numInputs + 1);
    localparam int AW1  = addrWidth + 1;
    localparam logic [CW-1:0]  LAST  = CW'(numInputs - 1);
    localparam logic [AW1-1:0] DEPTH = AW1'(numInputs);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, OUT} state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic signed [SW-1:0]   acc;
    logic signed [SW-1:0]   s2_prod;
    logic signed [SW-1:0]   bias_al;
    logic [dataWidth-1:0]   s1_dat;
    logic [dataWidth-1:0]   s1_wt;
    logic [dataWidth-1:0]   bias_reg;
    logic                   s1_vld;
    logic                   s2_vld;
    logic                   accept;
    logic                   cfg_open;
    logic                   wt_we;
    logic [addrWidth-1:0]   rd_addr;

    logic signed [dataWidth-1:0] wmem [numInputs];

    // Signed add in the product format; clamps on overflow only when saturation is built in.
    function automatic logic signed [SW-1:0] acc_add(input logic signed [SW-1:0] a,
                                                     input logic signed [SW-1:0] b);
        logic signed [SW-1:0] s;
        s = a + b;
`ifdef NEURON_SAT_EN
        if ((a[SW-1] == b[SW-1]) && (s[SW-1] != a[SW-1])) begin
            s = a[SW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    assign accept   = in_valid && in_ready;
    // Config is only open between evaluations; a write racing the first input still lands.
    assign cfg_open = (state == IDLE) && (count == '0);
    assign wt_we    = cfg_open && wt_wr && ({1'b0, wt_addr} < DEPTH);
    assign rd_addr  = count[addrWidth-1:0];
    // Bias sign-extended and moved up into the Q(2*intPart) product format.
    assign bias_al  = $signed({{dataWidth{bias_reg[dataWidth-1]}}, bias_reg}) <<< FRAC;

    // Weight memory write port and registered read of weight[count] for stage 1 (no reset, RAM-friendly).
    always_ff @(posedge clk) begin
        if (wt_we) begin
            wmem[wt_addr] <= wt_data;
        end
        if (accept) begin
            s1_wt <= wmem[rd_addr];
        end
    end

    // Stages 1 and 2: capture the activation, then form the full-precision signed product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s2_vld  <= 1'b0;
            s2_prod <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_dat <= in_data;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_prod <= $signed({{dataWidth{s1_dat[dataWidth-1]}}, s1_dat}) *
                           $signed({{dataWidth{s1_wt[dataWidth-1]}}, s1_wt});
            end
        end
    end

    // Control FSM with stage-3 accumulate, bias add and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            in_ready  <= 1'b1;
            bias_reg  <= '0;
        end else begin
            sum_valid <= 1'b0;
            if (cfg_open && bias_wr) begin
                bias_reg <= bias_data;
            end
            if (s2_vld) begin
                acc <= acc_add(acc, s2_prod);
            end
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        count <= count + CW'(1);
                        if (count == LAST) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_vld && !s2_vld) begin
                        state <= BIAS;
                    end
                end
                BIAS: begin
                    acc   <= acc_add(acc, bias_al);
                    state <= OUT;
                end
                OUT: begin
                    sum_out   <= acc;
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    count     <= '0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac with numInputs=4: directed test-plan cases plus randomized runs against a reference model.
// The model works in 64-bit integers and wraps or clamps each add to 32 bits depending on NEURON_SAT_EN.
// Each evaluation checks the ready/valid timing around the result and the sum value.
module tb_neuron_mac;

    localparam int NI = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wt_wr = 1'b0;
    logic [1:0]  wt_addr = '0;
    logic [15:0] wt_data = '0;
    logic        bias_wr = 1'b0;
    logic [15:0] bias_data = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        sum_valid;
    logic [31:0] sum_out;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    shortint tb_w [NI];
    shortint tb_x [NI];
    shortint tb_bias = 0;

    neuron_mac #(
        .dataWidth (16),
        .intPart   (4),
        .numInputs (NI)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wt_wr     (wt_wr),
        .wt_addr   (wt_addr),
        .wt_data   (wt_data),
        .bias_wr   (bias_wr),
        .bias_data (bias_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sum_valid (sum_valid),
        .sum_out   (sum_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint step(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef NEURON_SAT_EN
        if (s > SMAX) s = SMAX;
        else if (s < SMIN) s = SMIN;
`else
        s = longint'(int'(s));
`endif
        return s;
    endfunction

    // Weighted sum of the current model weights/inputs plus bias scaled to the product format.
    function automatic logic [31:0] expect_sum();
        longint acc;
        acc = 0;
        for (int i = 0; i < NI; i++) acc = step(acc, longint'(tb_w[i]) * longint'(tb_x[i]));
        acc = step(acc, longint'(tb_bias) * 64'sd4096);
        return acc[31:0];
    endfunction

    task automatic wr_wt(input logic [1:0] a, input logic [15:0] d);
        wt_wr = 1'b1; wt_addr = a; wt_data = d;
        @(posedge clk); #1;
        wt_wr = 1'b0;
        tb_w[a] = shortint'(d);
    endtask

    task automatic wr_bias(input logic [15:0] d);
        bias_wr = 1'b1; bias_data = d;
        @(posedge clk); #1;
        bias_wr = 1'b0;
        tb_bias = shortint'(d);
    endtask

    task automatic set_x(input logic [15:0] d);
        for (int i = 0; i < NI; i++) tb_x[i] = shortint'(d);
    endtask

    task automatic rand_x();
        for (int i = 0; i < NI; i++) tb_x[i] = shortint'(16'($urandom));
    endtask

    // One evaluation. wmode 1: weight write alongside the first input; wmode 2: weight+bias write alongside the second.
    task automatic run(input string tag, input int gap, input int wmode,
                       input logic [1:0] waddr, input logic [15:0] wdat);
        logic [31:0] exp_sum;
        int n;
        exp_sum = expect_sum();
        for (int i = 0; i < NI; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(tb_x[i]);
            if ((wmode == 1 && i == 0) || (wmode == 2 && i == 1)) begin
                wt_wr = 1'b1; wt_addr = waddr; wt_data = wdat;
                if (wmode == 2) begin
                    bias_wr = 1'b1; bias_data = 16'($urandom) | 16'h0100;
                end
            end
            n = 0;
            while (!in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0; wt_wr = 1'b0; bias_wr = 1'b0;
            if (i < NI - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
            end
        end
        check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_data = 16'($urandom);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            in_valid = (k <= 3);
            in_data  = 16'($urandom);
            check($sformatf("%s_valid_T%0d", tag, k), 32'(sum_valid), (k == 5) ? 32'd1 : 32'd0);
            if (k == 2) check({tag, "_ready_drain"}, 32'(in_ready), 32'd0);
            if (k == 5) check({tag, "_sum"}, sum_out, exp_sum);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] nw;
        bit seen;

        rst_n = 1'b0;
        #12;
        check("rst_sum_out", sum_out, 32'd0);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NI; i++) wr_wt(2'(i), 16'h1000);
        wr_bias(16'h0000);
        set_x(16'h1000);
        run("unit_b0", 0, 0, 2'd0, 16'h0);

        wr_bias(16'h0800);
        run("unit_bhalf", 0, 0, 2'd0, 16'h0);

        for (int i = 0; i < NI; i++) wr_wt(2'(i), 16'hF000);
        wr_bias(16'h0000);
        run("neg_b2b", 0, 0, 2'd0, 16'h0);
        run("neg_gap2", 2, 0, 2'd0, 16'h0);

        for (int i = 0; i < NI; i++) wr_wt(2'(i), 16'h7FFF);
        set_x(16'h7FFF);
        run("max_ovf", 0, 0, 2'd0, 16'h0);

        for (int i = 0; i < NI; i++) wr_wt(2'(i), 16'($urandom));
        wr_bias(16'($urandom));
        rand_x();
        run("drop_wr", 1, 2, 2'd2, ~16'(tb_w[2]));
        rand_x();
        run("after_drop", 0, 0, 2'd0, 16'h0);

        nw = 16'($urandom) | 16'h0010;
        tb_w[1] = shortint'(nw);
        run("first_wr_a1", 0, 1, 2'd1, nw);
        nw = ~16'(tb_w[0]);
        run("first_wr_a0", 0, 1, 2'd0, nw);
        tb_w[0] = shortint'(nw);
        rand_x();
        run("a0_persist", 0, 0, 2'd0, 16'h0);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NI; i++) wr_wt(2'(i), 16'($urandom));
            wr_bias(16'($urandom));
            rand_x();
            run($sformatf("rand%0d", r), int'($urandom_range(0, 3)), 0, 2'd0, 16'h0);
        end

        rand_x();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(tb_x[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("mid_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sum_out", sum_out, 32'd0);
        check("mid_rst_sum_valid", 32'(sum_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tb_bias = 0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (sum_valid) seen = 1'b1;
        end
        check("mid_rst_no_pulse", 32'(seen), 32'd0);
        rand_x();
        run("post_rst", 0, 0, 2'd0, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
